// File: rtl/ddr3_rd_arbiter_if.sv
// Requester-side read channel: address/len/id request plus zero-latency return data.
// Data and ID are broadcast; rd_data_valid marks beats owned by this requester.
interface ddr3_rd_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int LEN_W  = 4,
   parameter int ID_W   = 4,
   parameter int DATA_W = 256
);
   logic [ADDR_W-1:0] rd_addr;
   logic [LEN_W-1:0]  rd_len;
   logic [ID_W-1:0]   rd_id;
   logic              rd_addr_valid;
   logic              rd_addr_ready;
   logic              rd_data_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ID_W-1:0]   rd_back_id;
   logic              rd_data_last;

   modport master (
      output rd_addr, rd_len, rd_id, rd_addr_valid,
      input  rd_addr_ready, rd_data_valid, rd_data, rd_back_id, rd_data_last
   );

   modport slave (
      input  rd_addr, rd_len, rd_id, rd_addr_valid,
      output rd_addr_ready, rd_data_valid, rd_data, rd_back_id, rd_data_last
   );
endinterface

// File: rtl/ddr3_rd_arbiter.sv
// Round-robin share of one DDR3 read port between two requesters, one burst in flight, locked to its owner.
// Request reaches DDR one cycle after grant; data passes through with zero latency and no backpressure.
module ddr3_rd_arbiter #(
   parameter int ADDR_W  = 28,
   parameter int LEN_W   = 4,
   parameter int ID_W    = 4,
   parameter int DATA_W  = 256,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   ddr3_rd_arbiter_if.slave  m0,
   ddr3_rd_arbiter_if.slave  m1,
   output logic [ADDR_W-1:0] RD_ADDR,
   output logic [LEN_W-1:0]  RD_LEN,
   output logic [ID_W-1:0]   RD_ID,
   output logic              RD_ADDR_VALID,
   input  logic              RD_ADDR_READY,
   input  logic [DATA_W-1:0] RD_DATA,
   input  logic [ID_W-1:0]   RD_BACK_ID,
   input  logic              RD_DATA_LAST,
   input  logic              RD_DATA_VALID,
   output logic              busy,
   output logic              err_len,
   output logic              err_timeout
);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              err_len_q, err_len_d;
   logic              err_timeout_q, err_timeout_d;
   // Holds the broadcast return path at zero from reset until the first clock.
   logic              out_en_q, out_en_d;

   logic              rdy0, rdy1, dv0, dv1;
   logic              beat_last, burst_end;
   logic [LEN_W-1:0]  g_len;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      len_d         = len_q;
      beat_cnt_d    = beat_cnt_q;
      wdog_d        = wdog_q;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      out_en_d      = 1'b1;
      RD_ADDR       = '0;
      RD_LEN        = '0;
      RD_ID         = '0;
      RD_ADDR_VALID = 1'b0;
      rdy0          = 1'b0;
      rdy1          = 1'b0;
      dv0           = 1'b0;
      dv1           = 1'b0;
      g_len         = grant_q ? m1.rd_len : m0.rd_len;
      beat_last     = (beat_cnt_q == len_q);
      burst_end     = RD_DATA_VALID && (beat_last || RD_DATA_LAST);

      case (state_q)
         IDLE: begin
            if (m0.rd_addr_valid || m1.rd_addr_valid) begin
               if (m0.rd_addr_valid && m1.rd_addr_valid) grant_d = ~last_grant_q;
               else                                      grant_d = m1.rd_addr_valid;
               last_grant_d = grant_d;
               state_d      = ADDR;
            end
            err_len_d = RD_DATA_VALID;
         end
         ADDR: begin
            RD_ADDR_VALID = 1'b1;
            RD_ADDR       = grant_q ? m1.rd_addr : m0.rd_addr;
            RD_LEN        = g_len;
            RD_ID         = grant_q ? m1.rd_id : m0.rd_id;
            rdy0          = RD_ADDR_READY && !grant_q;
            rdy1          = RD_ADDR_READY && grant_q;
            err_len_d     = RD_DATA_VALID;
            if (RD_ADDR_READY) begin
               len_d      = g_len;
               beat_cnt_d = '0;
               wdog_d     = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            dv0 = RD_DATA_VALID && !grant_q;
            dv1 = RD_DATA_VALID && grant_q;
            if (wdog_q != WD_MAX) wdog_d = wdog_q + 1'b1;
            if (RD_DATA_VALID) begin
               if (!beat_last) beat_cnt_d = beat_cnt_q + 1'b1;
               // Count and DDR LAST flag must agree on the ending beat.
               err_len_d = (beat_last != RD_DATA_LAST);
            end
            if (burst_end) begin
               state_d = IDLE;
            end else if (wdog_q == WD_MAX) begin
               state_d       = IDLE;
               err_timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         len_q         <= '0;
         beat_cnt_q    <= '0;
         wdog_q        <= '0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         out_en_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         len_q         <= len_d;
         beat_cnt_q    <= beat_cnt_d;
         wdog_q        <= wdog_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         out_en_q      <= out_en_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;

   assign m0.rd_addr_ready = rdy0;
   assign m1.rd_addr_ready = rdy1;
   assign m0.rd_data_valid = dv0;
   assign m1.rd_data_valid = dv1;
   assign m0.rd_data       = out_en_q ? RD_DATA      : '0;
   assign m1.rd_data       = out_en_q ? RD_DATA      : '0;
   assign m0.rd_back_id    = out_en_q ? RD_BACK_ID   : '0;
   assign m1.rd_back_id    = out_en_q ? RD_BACK_ID   : '0;
   assign m0.rd_data_last  = out_en_q && RD_DATA_LAST;
   assign m1.rd_data_last  = out_en_q && RD_DATA_LAST;
endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Bench for ddr3_rd_arbiter: table of request scenarios with a DDR responder model,
// a scoreboard of expected address handshakes, and hand sequences for stray beats and reset.
module tb_ddr3_rd_arbiter;
   localparam int ADDR_W  = 28;
   localparam int LEN_W   = 4;
   localparam int ID_W    = 4;
   localparam int DATA_W  = 256;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rstn;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [LEN_W-1:0]  RD_LEN;
   logic [ID_W-1:0]   RD_ID;
   logic              RD_ADDR_VALID;
   logic              RD_ADDR_READY;
   logic [DATA_W-1:0] RD_DATA;
   logic [ID_W-1:0]   RD_BACK_ID;
   logic              RD_DATA_LAST;
   logic              RD_DATA_VALID;
   logic              busy, err_len, err_timeout;

   ddr3_rd_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .DATA_W(DATA_W)) m0_if ();
   ddr3_rd_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .DATA_W(DATA_W)) m1_if ();

   ddr3_rd_arbiter #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn), .m0(m0_if.slave), .m1(m1_if.slave),
      .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID), .RD_ADDR_VALID(RD_ADDR_VALID),
      .RD_ADDR_READY(RD_ADDR_READY), .RD_DATA(RD_DATA), .RD_BACK_ID(RD_BACK_ID),
      .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID),
      .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // last_at: -2 = DDR ends burst at LEN, -1 = DDR returns nothing, k = DDR raises LAST on beat k
   typedef struct {
      bit r0; bit r1; bit first;
      int len0; int len1; int last_at; int rdy_dly;
      int e_dv0; int e_dv1; int e_elen; int e_eto; int e_lat; int e_to_lat;
   } vec_t;

   typedef struct {
      bit                who;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [ID_W-1:0]   id;
   } hs_t;

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   hs_t exp_q[$];
   vec_t vecs[8];

   bit  ddr_busy, start_ddr, stray_pend, drop0, drop1, hs_any;
   int  ddr_idx, ddr_cur_last, ddr_over, av_cnt, rdy_dly;
   logic [ID_W-1:0] ddr_id;
   int  cnt_dv0, cnt_dv1, cnt_elen, cnt_eto, cnt_rdy0, cnt_rdy1;
   int  start_cyc, first_lat, hs_cyc, to_lat;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk256(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit r0, bit r1, bit first, int len0, int len1, int last_at, int dly,
                               int dv0, int dv1, int elen, int eto, int lat, int tolat);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.first = first; v.len0 = len0; v.len1 = len1;
      v.last_at = last_at; v.rdy_dly = dly; v.e_dv0 = dv0; v.e_dv1 = dv1;
      v.e_elen = elen; v.e_eto = eto; v.e_lat = lat; v.e_to_lat = tolat;
      return v;
   endfunction

   function automatic hs_t req_of(bit who, int idx, int len);
      hs_t h;
      h.who  = who;
      h.addr = ADDR_W'(32'h0100000 * (who ? 2 : 1) + idx * 64);
      h.len  = LEN_W'(len);
      h.id   = ID_W'(who ? 15 - idx : idx);
      return h;
   endfunction

   // One cycle: observe at negedge, then drive requester/DDR responses 1ns after posedge.
   task automatic step();
      hs_t e;
      @(negedge clk);
      cyc++;
      drop0 = m0_if.rd_addr_ready;
      drop1 = m1_if.rd_addr_ready;
      cnt_rdy0 += int'(m0_if.rd_addr_ready);
      cnt_rdy1 += int'(m1_if.rd_addr_ready);
      if (RD_ADDR_VALID && RD_ADDR_READY) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL hs_unexpected: got addr %0h expected no request", RD_ADDR);
         end else begin
            e = exp_q.pop_front();
            chk("grant_m1", int'(m1_if.rd_addr_ready), int'(e.who));
            chk("grant_m0", int'(m0_if.rd_addr_ready), int'(!e.who));
            chk("rd_addr", int'(RD_ADDR), int'(e.addr));
            chk("rd_len", int'(RD_LEN), int'(e.len));
            chk("rd_id", int'(RD_ID), int'(e.id));
            if (!hs_any) first_lat = cyc - start_cyc - 1;
            hs_any = 1'b1;
            hs_cyc = cyc;
            start_ddr = 1'b1;
            ddr_id = RD_ID;
            ddr_cur_last = (ddr_over == -2) ? int'(RD_LEN) : ddr_over;
         end
         av_cnt = 0;
      end else if (RD_ADDR_VALID) begin
         av_cnt++;
      end
      if (RD_DATA_VALID && rstn) begin
         chk256("m0_rd_data", m0_if.rd_data, RD_DATA);
         chk256("m1_rd_data", m1_if.rd_data, RD_DATA);
         chk("back_id", int'(m0_if.rd_back_id), int'(RD_BACK_ID));
         chk("data_last", int'(m1_if.rd_data_last), int'(RD_DATA_LAST));
         chk("dv_exclusive", int'(m0_if.rd_data_valid && m1_if.rd_data_valid), 0);
      end
      cnt_dv0 += int'(m0_if.rd_data_valid);
      cnt_dv1 += int'(m1_if.rd_data_valid);
      cnt_elen += int'(err_len);
      if (err_timeout) begin
         cnt_eto++;
         if (to_lat < 0) to_lat = cyc - hs_cyc;
      end
      @(posedge clk);
      #1;
      if (drop0) m0_if.rd_addr_valid = 1'b0;
      if (drop1) m1_if.rd_addr_valid = 1'b0;
      RD_ADDR_READY = (av_cnt >= rdy_dly);
      if (start_ddr) begin
         ddr_busy  = (ddr_cur_last >= 0);
         ddr_idx   = 0;
         start_ddr = 1'b0;
      end
      if (ddr_busy || stray_pend) begin
         for (int k = 0; k < DATA_W / 32; k++) RD_DATA[k*32 +: 32] = $urandom;
         RD_DATA[0]    = 1'b1;
         RD_DATA_VALID = 1'b1;
         RD_BACK_ID    = ddr_id;
         if (ddr_busy) begin
            RD_DATA_LAST = (ddr_idx == ddr_cur_last);
            ddr_idx++;
            if (ddr_idx > ddr_cur_last) ddr_busy = 1'b0;
         end else begin
            RD_DATA_LAST = 1'b1;
            stray_pend   = 1'b0;
         end
      end else begin
         RD_DATA_VALID = 1'b0;
         RD_DATA_LAST  = 1'b0;
      end
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      hs_t h;
      cnt_dv0 = 0; cnt_dv1 = 0; cnt_elen = 0; cnt_eto = 0; cnt_rdy0 = 0; cnt_rdy1 = 0;
      first_lat = -1; to_lat = -1; hs_any = 1'b0; av_cnt = 0;
      rdy_dly = v.rdy_dly;
      ddr_over = v.last_at;
      RD_ADDR_READY = (rdy_dly == 0);
      if (v.r0) begin
         h = req_of(1'b0, idx, v.len0);
         m0_if.rd_addr = h.addr; m0_if.rd_len = h.len; m0_if.rd_id = h.id;
         m0_if.rd_addr_valid = 1'b1;
      end
      if (v.r1) begin
         h = req_of(1'b1, idx, v.len1);
         m1_if.rd_addr = h.addr; m1_if.rd_len = h.len; m1_if.rd_id = h.id;
         m1_if.rd_addr_valid = 1'b1;
      end
      if (v.r0 && v.r1) begin
         exp_q.push_back(req_of(v.first, idx, v.first ? v.len1 : v.len0));
         exp_q.push_back(req_of(!v.first, idx, v.first ? v.len0 : v.len1));
      end else if (v.r0) begin
         exp_q.push_back(req_of(1'b0, idx, v.len0));
      end else if (v.r1) begin
         exp_q.push_back(req_of(1'b1, idx, v.len1));
      end
      start_cyc = cyc;
   endtask

   task automatic drain(input string name, input int budget);
      int  quiet;
      bit  done;
      quiet = 0;
      done  = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         step();
         if (exp_q.size() == 0 && !ddr_busy && !stray_pend && !busy &&
             !m0_if.rd_addr_valid && !m1_if.rd_addr_valid) quiet++;
         else quiet = 0;
         if (quiet >= 3) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_drain: got pending=%0d busy=%0d expected idle within %0d cycles",
                  name, exp_q.size(), busy, budget);
         exp_q.delete();
         ddr_busy = 1'b0;
         m0_if.rd_addr_valid = 1'b0;
         m1_if.rd_addr_valid = 1'b0;
      end
   endtask

   task automatic finish_vec(input vec_t v);
      chk("dv0_beats", cnt_dv0, v.e_dv0);
      chk("dv1_beats", cnt_dv1, v.e_dv1);
      chk("err_len_pulses", cnt_elen, v.e_elen);
      chk("err_timeout_pulses", cnt_eto, v.e_eto);
      chk("m0_ready_pulses", cnt_rdy0, int'(v.r0));
      chk("m1_ready_pulses", cnt_rdy1, int'(v.r1));
      chk("ready_latency", first_lat, v.e_lat);
      if (v.e_to_lat > 0) chk("timeout_latency", to_lat, v.e_to_lat);
   endtask

   initial begin
      vec_t sv;
      bit   got;
      rstn = 1'b0;
      RD_ADDR_READY = 1'b0; RD_DATA = '0; RD_BACK_ID = '0; RD_DATA_LAST = 1'b0; RD_DATA_VALID = 1'b0;
      m0_if.rd_addr = '0; m0_if.rd_len = '0; m0_if.rd_id = '0; m0_if.rd_addr_valid = 1'b0;
      m1_if.rd_addr = '0; m1_if.rd_len = '0; m1_if.rd_id = '0; m1_if.rd_addr_valid = 1'b0;
      ddr_busy = 1'b0; start_ddr = 1'b0; stray_pend = 1'b0; drop0 = 1'b0; drop1 = 1'b0;
      ddr_idx = 0; ddr_cur_last = 0; ddr_over = -2; av_cnt = 0; rdy_dly = 0; ddr_id = '0;
      hs_cyc = 0; hs_any = 1'b0;

      //      r0 r1 fst len0 len1 last dly dv0 dv1 elen eto lat tolat
      vecs[0] = mk(1, 0, 0, 3, 0, -2, 0, 4, 0, 0, 0, 1, 0);
      vecs[1] = mk(0, 1, 0, 0, 2, -2, 2, 0, 3, 0, 0, 3, 0);
      vecs[2] = mk(1, 1, 0, 1, 4, -2, 0, 2, 5, 0, 0, 1, 0);
      vecs[3] = mk(1, 1, 0, 0, 15, -2, 1, 1, 16, 0, 0, 2, 0);
      vecs[4] = mk(1, 0, 0, 7, 0, 5, 0, 6, 0, 1, 0, 1, 0);
      vecs[5] = mk(0, 1, 0, 0, 3, 5, 0, 0, 4, 3, 0, 1, 0);
      vecs[6] = mk(1, 0, 0, 1, 0, -1, 0, 0, 0, 0, 1, 1, TIMEOUT + 1);
      vecs[7] = mk(1, 1, 1, 2, 0, -2, 0, 3, 1, 0, 0, 1, 0);

      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr_valid", int'(RD_ADDR_VALID), 0);
      chk("rst_err_len", int'(err_len), 0);
      chk("rst_err_timeout", int'(err_timeout), 0);
      chk("rst_m0_ready", int'(m0_if.rd_addr_ready), 0);
      chk("rst_m1_dv", int'(m1_if.rd_data_valid), 0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         apply_vec(vecs[i], i);
         drain($sformatf("vec%0d", i), 200 + 2 * TIMEOUT);
         finish_vec(vecs[i]);
      end

      // Stray beat while idle: dropped, no owner sees it, err_len pulses once.
      sv = mk(0, 0, 0, 0, 0, -2, 0, 0, 0, 1, 0, -1, 0);
      apply_vec(sv, 10);
      stray_pend = 1'b1;
      drain("stray", 50);
      finish_vec(sv);

      // Reset in the middle of an m0 burst, then a tie must go to m0 again.
      sv = mk(1, 0, 0, 15, 0, -2, 0, 0, 0, 0, 0, 1, 0);
      apply_vec(sv, 11);
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         step();
         if (cnt_dv0 >= 3) got = 1'b1;
      end
      chk("mid_burst_reached", int'(got), 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_addr_valid", int'(RD_ADDR_VALID), 0);
      chk("arst_m0_dv", int'(m0_if.rd_data_valid), 0);
      chk("arst_m1_dv", int'(m1_if.rd_data_valid), 0);
      chk256("arst_m0_data", m0_if.rd_data, '0);
      chk("arst_err_len", int'(err_len), 0);
      chk("arst_err_timeout", int'(err_timeout), 0);
      ddr_busy = 1'b0;
      exp_q.delete();
      step();
      step();
      #2;
      rstn = 1'b1;
      sv = mk(1, 1, 0, 2, 1, -2, 0, 3, 2, 0, 0, 1, 0);
      apply_vec(sv, 12);
      drain("post_reset", 200);
      finish_vec(sv);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
